sw_debounce_irq: RTL
====================

# sw_debounce_irq

Switch-input peripheral for `miriscv_top`. It synchronises and debounces the 16 board switches, exposes the stable value and a sticky change mask as memory-mapped registers, and raises an interrupt request toward the core's interrupt controller whenever the debounced value changes. It sits between the `sw_i` pads and the core's data bus and `int_req`/`int_fin` lines, upstream of the core.

## Interface
- `WIDTH`, 16: number of switch inputs (1..32).
- `DEBOUNCE_CYCLES`, 16: clock cycles of unchanged synchronised input required before commit (≥2).
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `sw_i` in WIDTH: raw asynchronous switch levels.
- `req_i` in 1: bus access strobe, one cycle per access.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 4: byte address within block; bits [1:0] ignored.
- `wdata_i` in 32: write data.
- `rdata_o` out 32: read data, registered.
- `int_req_o` out 1: interrupt request, level.
- `int_fin_i` in 1: one-cycle pulse from core; interrupt serviced.

## Operation
- Synchroniser: 2-flop chain `s1`→`s2` per bit. There is no combinational path from `sw_i`.
- Debouncer: whole-vector. Registers are `cand` (WIDTH), `cnt` (width to hold DEBOUNCE_CYCLES-1), and `stable` (WIDTH).
  - If `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - Else if `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - Else, if `cand != stable`: commit `stable <= cand`.
- On commit: `changed <= changed | (cand ^ stable)`, `pending <= 1`.
- `int_req_o = pending & ctrl_en`.
- `int_fin_i` clears `pending`. If a commit occurs on the same edge, set wins and `pending` stays 1.
- Register map (word offsets):
  - 0x0 STATE: RO, `{0, stable}`.
  - 0x4 CHANGED: write-1-to-clear of `changed` bits. If a commit sets a bit on the same edge as a W1C, set wins.
  - 0x8 CTRL: bit0 `ctrl_en` is RW. Other bits read 0 and writes to them are ignored.
  - 0xC: reads 0, writes ignored.
- Reads have no side effects.
- Reset values: `s1`, `s2`, `cand`, `stable`, `changed`, `cnt` = 0; `pending` = 0; `ctrl_en` = 0; `rdata_o` = 0; `int_req_o` = 0.
- Reset mid-debounce discards all progress. After release, any nonzero `sw_i` commits as a change from 0 (sets `pending`). Software clears it before setting `ctrl_en`.

## Timing
- Define E1 as the first clock edge that samples a new `sw_i` held stable:
  - E2: `s2` updates.
  - E3: `cand` updates, `cnt` = 0.
  - E(DEBOUNCE_CYCLES+2): `cnt` reaches DEBOUNCE_CYCLES-1.
  - E(DEBOUNCE_CYCLES+3): `stable`, `changed`, and `pending` update. `int_req_o` goes high after this edge if `ctrl_en`=1. With the default parameter this is E19.
- Any change of `s2` before commit restarts the count. Input activity shorter than DEBOUNCE_CYCLES cycles never commits; this includes sub-cycle glitches.
- Reads: `req_i`=1, `we_i`=0 at edge N gives `rdata_o` valid after edge N and held until the next read. A read and a commit on the same edge return the pre-commit value.
- Writes take effect at the edge where `req_i`=1, `we_i`=1.
- `int_req_o` falls after the edge sampling `int_fin_i`=1, unless a commit occurs on the same edge. It also falls after the edge where CTRL is written with bit0=0.
- `int_fin_i` with `pending`=0: no effect.

## Test plan
- Reset with `sw_i`=16'h0000, then drive 16'h1111 and set CTRL=1:
  - `int_req_o` stays 0 until `pending` sets. `stable` reads 16'h1111 exactly 19 edges after the first sampling edge.
  - CHANGED reads 16'h1111.
- With stable 16'h1111, drive 16'h1011 for 2 ns and then 16'h1111 again:
  - No commit occurs. STATE stays 16'h1111 and `pending` stays 0.
- With stable 16'h1111, drive 16'h1110 for 10 cycles and then 16'h1111: no commit.
  - Then drive 16'h1110 for 30 cycles: commit occurs, CHANGED |= 16'h0001, and `int_req_o`=1.
  - Pulse `int_fin_i`: `int_req_o` = 0 after the next edge.
- Write CHANGED = 16'h0001 on the same edge as a commit that flips bit 0:
  - Bit 0 remains 1.
  - `int_fin_i` on the same edge as a commit: `pending` remains 1.
- Assert `rst_n_i` low asynchronously mid-count, for example at `cnt`=8:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release with `sw_i`=16'h1111, commit occurs 19 edges later.
- Read 0xC, and write 0xFFFFFFFF to CTRL:
  - The 0xC read returns 0.
  - CTRL reads 1.
  - Read latency is exactly one edge.

Source files
------------

// File: rtl/sw_debounce_irq.sv
// rtl/sw_debounce_irq.sv - switch synchroniser/debouncer with change mask registers and interrupt request
module sw_debounce_irq #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] sw_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [3:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             int_req_o,
  input  logic             int_fin_i
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] REG_STATE   = 2'd0;
  localparam logic [1:0] REG_CHANGED = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;

  logic [WIDTH-1:0] s1, s2, cand, stable, changed;
  logic [CW-1:0]    cnt;
  logic             pending, ctrl_en;
  logic             commit, wr_changed, wr_ctrl, rd;
  logic [WIDTH-1:0] commit_diff, w1c_mask;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  // A commit needs the candidate held for the full count and different from what is already committed.
  assign commit      = (s2 == cand) && (cnt == CNT_LAST) && (cand != stable);
  assign commit_diff = commit ? (cand ^ stable) : '0;

  assign rd          = req_i & ~we_i;
  assign wr_changed  = req_i & we_i & (addr_i[3:2] == REG_CHANGED);
  assign wr_ctrl     = req_i & we_i & (addr_i[3:2] == REG_CTRL);
  assign w1c_mask    = wr_changed ? wdata_i[WIDTH-1:0] : '0;
  assign unused_bits = ^{addr_i[1:0], wdata_i};

  always_comb begin
    rd_mux = '0;
    case (addr_i[3:2])
      REG_STATE:   rd_mux = 32'(stable);
      REG_CHANGED: rd_mux = 32'(changed);
      REG_CTRL:    rd_mux = {31'd0, ctrl_en};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_i;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt < CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end
      if (commit) stable <= cand;
    end
  end

  // Setting from a commit wins over a same-edge clear, for both the mask and the pending flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      changed <= '0;
      pending <= 1'b0;
      ctrl_en <= 1'b0;
      rdata_o <= '0;
    end else begin
      changed <= (changed & ~w1c_mask) | commit_diff;
      if (commit)         pending <= 1'b1;
      else if (int_fin_i) pending <= 1'b0;
      if (wr_ctrl)        ctrl_en <= wdata_i[0];
      if (rd)             rdata_o <= rd_mux;
    end
  end

  assign int_req_o = pending & ctrl_en;

endmodule
